// File: rtl/xorshift_pkg.sv
// Shared types and helpers for the xorshift range sampler.
//   state_e        : sampler FSM state encoding
//   RND_W          : width of the generator word
//   mask_for_bound : smallest all-ones mask covering N-1 (N=0 -> full width)
package xorshift_pkg;

   localparam int unsigned RND_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      RUN   = 2'd2
   } state_e;

   // Smear the MSB of N-1 downwards; N=0 wraps to all-ones, N=1 gives 0.
   function automatic logic [15:0] mask_for_bound(input logic [15:0] n,
                                                  input int unsigned out_w);
      logic [15:0] m;
      logic [15:0] full;
      full = 16'hFFFF >> 5'(16 - out_w);
      m    = n - 16'd1;
      m    = m | (m >> 1);
      m    = m | (m >> 2);
      m    = m | (m >> 4);
      m    = m | (m >> 8);
      return m & full;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : synchronous clear (wins over push/pop)
//   push_i    : write data_i (accepted when not full, or full with pop)
//   pop_i     : drop the head entry (ignored when empty)
//   data_o    : head entry, 0 when empty
//   full_o, empty_o, count_o : occupancy status
module sync_fifo_fwft #(
   parameter  int unsigned W     = 8,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [W-1:0]     data_i,
   output logic [W-1:0]     data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   // Pointer/count update; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      do_pop  = pop_i && (count_q != '0);
      do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + PTR_W'(1);
      if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
      if (clr_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: data_o is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push && !clr_i) mem_q[wptr_q] <= data_i;
   end

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign data_o  = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/xorshift_range_sampler.sv
// Turns xorshift32 words into unbiased samples in [0, N) by mask-and-reject,
// buffering accepted samples in a FWFT FIFO behind a valid/ready port.
//   clk, rst   : clock, asynchronous active-high reset
//   cfg_load   : pulse, latch cfg_bound (N, 0 = 2^OUT_W) and restart sampling
//   prng_en    : generator advance enable (credit-gated on FIFO space)
//   rnd_in     : generator word, valid the cycle after prng_en
//   out_valid/out_ready/out_data : sample stream
//   busy       : high in RUN
//   rej_cnt    : saturating rejected-word count (only with XORSHIFT_RANGE_STATS_EN)
module xorshift_range_sampler
   import xorshift_pkg::*;
#(
   parameter int unsigned OUT_W      = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_load,
   input  logic [OUT_W-1:0] cfg_bound,
   output logic             prng_en,
   input  logic [RND_W-1:0] rnd_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             busy
`ifdef XORSHIFT_RANGE_STATS_EN
   ,
   output logic [15:0]      rej_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   state_e           state_q, state_d;
   logic [OUT_W-1:0] bound_q, bound_d;
   logic [OUT_W-1:0] mask_q, mask_d;
   logic             pend_q, pend_d;
   logic             clr;
   logic             push;
   logic             pop;
   logic             reject;
   logic             accept;
   logic [OUT_W-1:0] cand;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   credit_c;
   logic             fifo_full;
   logic             fifo_empty;
   logic             unused_rnd_c;

   assign unused_rnd_c = ^rnd_in[RND_W-1:OUT_W];

   // Candidate from the fresh word; bound 0 means full range.
   assign cand     = rnd_in[OUT_W-1:0] & mask_q;
   assign accept   = (bound_q == '0) || (cand < bound_q);
   // Words already requested count against FIFO space so a push never overflows.
   assign credit_c = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(pend_q);

   // Next state, credit-gated enable and push/reject decisions.
   always_comb begin
      state_d = state_q;
      bound_d = bound_q;
      mask_d  = mask_q;
      clr     = 1'b0;
      push    = 1'b0;
      reject  = 1'b0;
      prng_en = (state_q == RUN) && !fifo_full &&
                (credit_c < (CNT_W + 1)'(FIFO_DEPTH));

      case (state_q)
         IDLE:    if (cfg_load) state_d = FLUSH;
         FLUSH: begin
            clr     = 1'b1;
            state_d = cfg_load ? FLUSH : RUN;
         end
         RUN:     if (cfg_load) state_d = FLUSH;
         default: state_d = IDLE;
      endcase

      // Clearing on the load edge empties the FIFO before the FLUSH cycle.
      if (cfg_load) begin
         bound_d = cfg_bound;
         mask_d  = OUT_W'(mask_for_bound(16'(cfg_bound), OUT_W));
         clr     = 1'b1;
      end

      if ((state_q == RUN) && pend_q && !clr) begin
         if (accept) push   = 1'b1;
         else        reject = 1'b1;
      end

      pend_d = prng_en && !clr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         bound_q <= '0;
         mask_q  <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bound_q <= bound_d;
         mask_q  <= mask_d;
         pend_q  <= pend_d;
      end
   end

   assign pop = out_valid && out_ready && (state_q != FLUSH);

   sync_fifo_fwft #(
      .W     (OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (cand),
      .data_o  (out_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign out_valid = !fifo_empty;
   assign busy      = (state_q == RUN);

`ifdef XORSHIFT_RANGE_STATS_EN
   logic [15:0] rej_q, rej_d;

   // Saturating reject counter, cleared with the FIFO.
   always_comb begin
      rej_d = rej_q;
      if (clr)                              rej_d = '0;
      else if (reject && rej_q != 16'hFFFF) rej_d = rej_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rej_q <= '0;
      else     rej_q <= rej_d;
   end

   assign rej_cnt = rej_q;
`else
   logic unused_reject;
   assign unused_reject = reject;
`endif

endmodule

// File: tb/tb_xorshift_range_sampler.sv
// Bench for xorshift_range_sampler: drives rnd_in as a stand-in generator and
// compares against a queue-based reference model plus fixed vector tables.
module tb_xorshift_range_sampler;

   localparam int TB_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_load;
   logic [7:0]  cfg_bound;
   logic        prng_en;
   logic [31:0] rnd_in;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        busy;
`ifdef XORSHIFT_RANGE_STATS_EN
   logic [15:0] rej_cnt;
`endif

   always #5 clk = ~clk;

   xorshift_range_sampler #(
      .OUT_W      (8),
      .FIFO_DEPTH (TB_DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_load  (cfg_load),
      .cfg_bound (cfg_bound),
      .prng_en   (prng_en),
      .rnd_in    (rnd_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
`ifdef XORSHIFT_RANGE_STATS_EN
      ,
      .rej_cnt   (rej_cnt)
`endif
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state (spec-level: phase, sample queue, pending word)
   int         m_phase = 0;     // 0 idle, 1 flush, 2 run
   logic [7:0] m_q[$];
   bit         m_pend = 1'b0;
   int         m_bound = 0;
   int         m_mask  = 0;
   int         m_rej   = 0;

   // Generator stand-in and observed streams
   logic [31:0] words[$];
   bit          fill_fixed = 1'b0;
   logic [31:0] fill_word  = 32'h0;
   logic [7:0]  got[$];
   logic [7:0]  fed[$];

   typedef struct {
      logic [7:0]  bound;
      logic [31:0] word;
      bit          acc;
      logic [7:0]  val;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int calc_mask(input int n);
      int m;
      if (n == 0) return 255;
      m = 0;
      while (m < n - 1) m = m * 2 + 1;
      return m;
   endfunction

   function automatic bit model_en();
      return (m_phase == 2) && ((m_q.size() + int'(m_pend)) < TB_DEPTH);
   endfunction

   function automatic logic [31:0] next_word();
      if (words.size() > 0) return words.pop_front();
      if (fill_fixed)       return fill_word;
      return $urandom();
   endfunction

   task automatic check_outputs();
      chk("prng_en", 32'(prng_en), 32'(model_en()));
      chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      chk("busy", 32'(busy), 32'(m_phase == 2));
      if (m_q.size() > 0) chk("out_data", 32'(out_data), 32'(m_q[0]));
`ifdef XORSHIFT_RANGE_STATS_EN
      chk("rej_cnt", 32'(rej_cnt), 32'(m_rej));
`endif
   endtask

   // Advance the model across the coming clock edge.
   task automatic model_step();
      bit         en;
      logic [7:0] cand;
      en = model_en();
      if (rst) begin
         m_phase = 0; m_q.delete(); m_pend = 1'b0;
         m_bound = 0; m_mask = 0; m_rej = 0;
      end else if (cfg_load) begin
         m_bound = int'(cfg_bound);
         m_mask  = calc_mask(m_bound);
         m_q.delete(); m_pend = 1'b0; m_rej = 0; m_phase = 1;
      end else if (m_phase == 1) begin
         m_phase = 2; m_pend = 1'b0; m_rej = 0;
      end else if (m_phase == 2) begin
         if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
         if (m_pend) begin
            cand = rnd_in[7:0] & 8'(m_mask);
            if (m_bound == 0 || int'(cand) < m_bound) m_q.push_back(cand);
            else if (m_rej < 65535) m_rej++;
         end
         m_pend = en;
      end
   endtask

   // One clock cycle, entered and left at the falling edge.
   task automatic tick();
      bit en_now;
      if (!rst) check_outputs();
      if (!rst && !cfg_load && out_valid && out_ready) got.push_back(out_data);
      en_now = prng_en;
      model_step();
      @(posedge clk);
      @(negedge clk);
      if (en_now) begin
         rnd_in = next_word();
         fed.push_back(rnd_in[7:0]);
      end
   endtask

   task automatic do_cfg(input logic [7:0] n);
      cfg_bound = n;
      cfg_load  = 1'b1;
      tick();
      cfg_load  = 1'b0;
      tick();
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_prng_en"}, 32'(prng_en), 32'h0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
      chk({tag, "_out_data"}, 32'(out_data), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
`ifdef XORSHIFT_RANGE_STATS_EN
      chk({tag, "_rej_cnt"}, 32'(rej_cnt), 32'h0);
`endif
      for (int i = 0; i < 20; i++) begin
         tick();
         chk({tag, "_idle_en"}, 32'(prng_en), 32'h0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{8'd6,   32'h0000_0005, 1'b1, 8'd5};
      vecs[1]  = '{8'd6,   32'h0000_0007, 1'b0, 8'd0};
      vecs[2]  = '{8'd6,   32'h0000_0006, 1'b0, 8'd0};
      vecs[3]  = '{8'd6,   32'h0000_0003, 1'b1, 8'd3};
      vecs[4]  = '{8'd6,   32'h0000_000E, 1'b0, 8'd0};
      vecs[5]  = '{8'd1,   32'hDEAD_BEEF, 1'b1, 8'd0};
      vecs[6]  = '{8'd0,   32'h1234_56AA, 1'b1, 8'hAA};
      vecs[7]  = '{8'd255, 32'h0000_00FF, 1'b0, 8'd0};
      vecs[8]  = '{8'd255, 32'h0000_01FE, 1'b1, 8'hFE};
      vecs[9]  = '{8'd128, 32'h0000_0080, 1'b1, 8'd0};
      vecs[10] = '{8'd129, 32'h0000_0081, 1'b0, 8'd0};
      vecs[11] = '{8'd129, 32'hFFFF_FF80, 1'b1, 8'h80};
      vecs[12] = '{8'd3,   32'h0000_0013, 1'b0, 8'd0};
      vecs[13] = '{8'd3,   32'h0000_0042, 1'b1, 8'd2};
      vecs[14] = '{8'd2,   32'h0000_0003, 1'b1, 8'd1};

      rst       = 1'b1;
      cfg_load  = 1'b0;
      cfg_bound = 8'd0;
      out_ready = 1'b0;
      rnd_in    = 32'h0;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;

      // Reset state and no activity without cfg_load
      reset_check("t1");

      // Mask/accept vectors: word requested two edges after load, visible next
      out_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         do_cfg(vecs[i].bound);
         words.delete();
         words.push_back(vecs[i].word);
         tick();
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].acc));
         if (vecs[i].acc) chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].val));
      end

      // N=6 stream with continuous ready
      out_ready = 1'b1;
      do_cfg(8'd6);
      words.delete();
      words.push_back(32'h05); words.push_back(32'h07); words.push_back(32'h06);
      words.push_back(32'h03); words.push_back(32'h0E);
      fill_fixed = 1'b1;
      fill_word  = 32'h05;
      got.delete();
      repeat (15) tick();
      chk("t2_count", 32'(got.size() >= 2), 32'h1);
      if (got.size() >= 2) begin
         chk("t2_first", 32'(got[0]), 32'h05);
         chk("t2_second", 32'(got[1]), 32'h03);
      end
`ifdef XORSHIFT_RANGE_STATS_EN
      chk("t2_rej_cnt", 32'(rej_cnt), 32'd3);
`endif
      fill_fixed = 1'b0;

      // N=0 backpressure: four words fill the FIFO, fifth stays unrequested
      out_ready = 1'b0;
      do_cfg(8'd0);
      words.delete();
      words.push_back(32'hAA); words.push_back(32'h01); words.push_back(32'hFF);
      words.push_back(32'h10); words.push_back(32'h55);
      got.delete();
      repeat (10) tick();
      chk("t3_en_stalled", 32'(prng_en), 32'h0);
      chk("t3_valid", 32'(out_valid), 32'h1);
      chk("t3_head", 32'(out_data), 32'hAA);
      chk("t3_unconsumed", 32'(words.size()), 32'd1);
      out_ready = 1'b1;
      tick();
      chk("t3_en_resume", 32'(prng_en), 32'h1);
      repeat (6) tick();
      chk("t3_drained", 32'(got.size() >= 4), 32'h1);
      if (got.size() >= 4) begin
         chk("t3_d0", 32'(got[0]), 32'hAA);
         chk("t3_d1", 32'(got[1]), 32'h01);
         chk("t3_d2", 32'(got[2]), 32'hFF);
         chk("t3_d3", 32'(got[3]), 32'h10);
      end

      // Full FIFO then continuous push/pop: output stream equals fed words
      out_ready = 1'b0;
      do_cfg(8'd0);
      words.delete();
      got.delete();
      fed.delete();
      repeat (10) tick();
      chk("t4_full_valid", 32'(out_valid), 32'h1);
      chk("t4_full_en", 32'(prng_en), 32'h0);
      out_ready = 1'b1;
      repeat (70) tick();
      chk("t4_count", 32'(got.size() >= 50), 32'h1);
      if (got.size() >= 50 && fed.size() >= 50)
         for (int i = 0; i < 50; i++) chk($sformatf("t4_w%0d", i), 32'(got[i]), 32'(fed[i]));

      // Reconfigure with two entries buffered, then double load in FLUSH
      out_ready = 1'b0;
      do_cfg(8'd0);
      repeat (3) tick();
      chk("t5_two_valid", 32'(out_valid), 32'h1);
      cfg_bound = 8'd3;
      cfg_load  = 1'b1;
      tick();
      cfg_load  = 1'b0;
      chk("t5_flush_valid", 32'(out_valid), 32'h0);
      chk("t5_flush_busy", 32'(busy), 32'h0);
      got.delete();
      out_ready = 1'b1;
      repeat (60) tick();
      chk("t5_samples", 32'(got.size() > 0), 32'h1);
      foreach (got[i]) chk("t5_range3", 32'(got[i] < 8'd3), 32'h1);

      cfg_bound = 8'd6;
      cfg_load  = 1'b1;
      tick();
      cfg_bound = 8'd2;
      tick();
      cfg_load  = 1'b0;
      chk("t5_reflush_busy", 32'(busy), 32'h0);
      tick();
      chk("t5_run_busy", 32'(busy), 32'h1);
      got.delete();
      repeat (30) tick();
      chk("t5b_samples", 32'(got.size() > 0), 32'h1);
      foreach (got[i]) chk("t5b_range2", 32'(got[i] < 8'd2), 32'h1);

      // Asynchronous reset with a word in flight
      out_ready = 1'b1;
      do_cfg(8'd0);
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_en", 32'(prng_en), 32'h0);
      chk("t6_async_valid", 32'(out_valid), 32'h0);
      chk("t6_async_busy", 32'(busy), 32'h0);
      tick();
      tick();
      rst = 1'b0;
      out_ready = 1'b0;
      reset_check("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
